// File: rtl/weight_updater_pkg.sv
// Shared types and helpers for the weight updater: FSM encoding,
// arithmetic width helpers and saturation limits.
package weight_updater_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    CALC  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Width of the signed delta times the zero-extended unsigned activation.
  function automatic int prod_width(input int delta_width, input int act_width);
    return delta_width + act_width + 1;
  endfunction

  // Width that holds weight + step without overflow.
  function automatic int sum_width(input int weight_width, input int prod_w);
    return ((weight_width > prod_w) ? weight_width : prod_w) + 1;
  endfunction

  // Largest value a signed weight can hold.
  function automatic longint sat_max(input int weight_width);
    return (longint'(1) <<< (weight_width - 1)) - longint'(1);
  endfunction

  // Smallest value a signed weight can hold.
  function automatic longint sat_min(input int weight_width);
    return -(longint'(1) <<< (weight_width - 1));
  endfunction

endpackage

// File: rtl/weight_update_cell.sv
// One weight's gradient step: multiply, arithmetic shift (floor),
// widened add and saturate to the signed weight range.
module weight_update_cell
  import weight_updater_pkg::*;
#(
  parameter int DELTA_WIDTH  = 10,
  parameter int ACT_WIDTH    = 9,
  parameter int WEIGHT_WIDTH = 16,
  parameter int SHIFT        = 4
) (
  input  logic [DELTA_WIDTH-1:0]  delta,
  input  logic [ACT_WIDTH-1:0]    a,
  input  logic [WEIGHT_WIDTH-1:0] weight,
  output logic [WEIGHT_WIDTH-1:0] new_weight,
  output logic                    sat
);

  localparam int PW = prod_width(DELTA_WIDTH, ACT_WIDTH);
  localparam int SW = sum_width(WEIGHT_WIDTH, PW);
  localparam logic signed [SW-1:0] MAX_S = SW'(sat_max(WEIGHT_WIDTH));
  localparam logic signed [SW-1:0] MIN_S = SW'(sat_min(WEIGHT_WIDTH));

  logic signed [PW-1:0] delta_ext;
  logic signed [PW-1:0] a_ext;
  logic signed [PW-1:0] product;
  logic signed [PW-1:0] step;
  logic signed [SW-1:0] sum;

  assign delta_ext = PW'($signed(delta));
  assign a_ext     = PW'({1'b0, a});
  assign product   = delta_ext * a_ext;
  assign step      = product >>> SHIFT;
  assign sum       = SW'($signed(weight)) + SW'(step);

  // Clamp the widened sum back into the weight range and flag clipping.
  always_comb begin
    sat        = 1'b0;
    new_weight = sum[WEIGHT_WIDTH-1:0];
    if (sum > MAX_S) begin
      new_weight = MAX_S[WEIGHT_WIDTH-1:0];
      sat        = 1'b1;
    end else if (sum < MIN_S) begin
      new_weight = MIN_S[WEIGHT_WIDTH-1:0];
      sat        = 1'b1;
    end
  end

endmodule

// File: rtl/weight_updater.sv
// Walks the weight memory one row per neuron with a read / calc / write
// sequence, adding the learning step to every weight of the row.
module weight_updater
  import weight_updater_pkg::*;
#(
  parameter  int NEURON_NUM        = 5,
  parameter  int INPUT_NUM         = 4,
  parameter  int DELTA_CELL_WIDTH  = 10,
  parameter  int ACTIVATION_WIDTH  = 9,
  parameter  int WEIGHT_CELL_WIDTH = 16,
  parameter  int FRACTION_WIDTH    = 0,
  parameter  int LEARNING_SHIFT    = 4,
  localparam int ADDR_WIDTH        = (NEURON_NUM > 1) ? $clog2(NEURON_NUM) : 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NEURON_NUM*DELTA_CELL_WIDTH-1:0] delta,
  input  logic                                   delta_valid,
  output logic                                   delta_ready,
  input  logic [INPUT_NUM*ACTIVATION_WIDTH-1:0]  a,
  input  logic                                   a_valid,
  output logic                                   a_ready,
  output logic [ADDR_WIDTH-1:0]                  weight_addr,
  input  logic [INPUT_NUM*WEIGHT_CELL_WIDTH-1:0] weight_read_data,
  output logic [INPUT_NUM*WEIGHT_CELL_WIDTH-1:0] weight_write_data,
  output logic                                   weight_write_enable,
  output logic                                   done,
  output logic                                   error
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ROW = ADDR_WIDTH'(NEURON_NUM - 1);

  state_t                                 state;
  state_t                                 state_next;
  logic [ADDR_WIDTH-1:0]                  row;
  logic [NEURON_NUM*DELTA_CELL_WIDTH-1:0] delta_q;
  logic [INPUT_NUM*ACTIVATION_WIDTH-1:0]  a_q;
  logic [DELTA_CELL_WIDTH-1:0]            row_delta;
  logic [INPUT_NUM*WEIGHT_CELL_WIDTH-1:0] new_row;
  logic [INPUT_NUM-1:0]                   sat_vec;
  logic                                   accept;
  logic                                   last_row;

  // Both readies rise together only when both sides offer data in IDLE;
  // a reset cycle never counts as an accept.
  assign accept      = rst && (state == IDLE) && delta_valid && a_valid;
  assign delta_ready = accept;
  assign a_ready     = accept;
  assign last_row    = (row == LAST_ROW);

  // Select the latched delta cell belonging to the current row.
  always_comb begin
    row_delta = '0;
    for (int i = 0; i < NEURON_NUM; i++) begin
      if (row == ADDR_WIDTH'(i)) row_delta = delta_q[i*DELTA_CELL_WIDTH +: DELTA_CELL_WIDTH];
    end
  end

  for (genvar j = 0; j < INPUT_NUM; j++) begin : g_cell
    weight_update_cell #(
      .DELTA_WIDTH (DELTA_CELL_WIDTH),
      .ACT_WIDTH   (ACTIVATION_WIDTH),
      .WEIGHT_WIDTH(WEIGHT_CELL_WIDTH),
      .SHIFT       (FRACTION_WIDTH + LEARNING_SHIFT)
    ) u_cell (
      .delta     (row_delta),
      .a         (a_q[j*ACTIVATION_WIDTH +: ACTIVATION_WIDTH]),
      .weight    (weight_read_data[j*WEIGHT_CELL_WIDTH +: WEIGHT_CELL_WIDTH]),
      .new_weight(new_row[j*WEIGHT_CELL_WIDTH +: WEIGHT_CELL_WIDTH]),
      .sat       (sat_vec[j])
    );
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Operand latches, row counter, registered write row and sticky error.
  always_ff @(posedge clk) begin
    if (!rst) begin
      row               <= '0;
      delta_q           <= '0;
      a_q               <= '0;
      weight_write_data <= '0;
      error             <= 1'b0;
    end else begin
      if (accept) begin
        delta_q <= delta;
        a_q     <= a;
        error   <= 1'b0;
        row     <= '0;
      end
      if (state == CALC) begin
        weight_write_data <= new_row;
        if (|sat_vec) error <= 1'b1;
      end
      if (state == WRITE && !last_row) row <= row + 1'b1;
    end
  end

  // Next-state logic and per-state strobes and address.
  always_comb begin
    state_next          = state;
    weight_addr         = '0;
    weight_write_enable = 1'b0;
    done                = 1'b0;
    case (state)
      IDLE:  if (accept) state_next = READ;
      READ: begin
        weight_addr = row;
        state_next  = CALC;
      end
      CALC: begin
        weight_addr = row;
        state_next  = WRITE;
      end
      WRITE: begin
        weight_addr         = row;
        weight_write_enable = 1'b1;
        state_next          = last_row ? DONE : READ;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_weight_updater.sv
// Scoreboard bench for weight_updater: a memory model answers the DUT,
// a reference model predicts each row write at accept time, and a
// negedge monitor pops and compares as writes and done pulses appear.
module tb_weight_updater;

  localparam int N     = 5;
  localparam int IN    = 4;
  localparam int DW    = 10;
  localparam int AW    = 9;
  localparam int WW    = 16;
  localparam int FW    = 0;
  localparam int LS    = 4;
  localparam int SHIFT = FW + LS;
  localparam int ADW   = 3;
  localparam longint WMAX = 32767;
  localparam longint WMIN = -32768;

  logic              clk;
  logic              rst;
  logic [N*DW-1:0]   delta;
  logic              delta_valid;
  logic              delta_ready;
  logic [IN*AW-1:0]  a;
  logic              a_valid;
  logic              a_ready;
  logic [ADW-1:0]    weight_addr;
  logic [IN*WW-1:0]  weight_read_data;
  logic [IN*WW-1:0]  weight_write_data;
  logic              weight_write_enable;
  logic              done;
  logic              error;

  weight_updater #(
    .NEURON_NUM(N), .INPUT_NUM(IN), .DELTA_CELL_WIDTH(DW), .ACTIVATION_WIDTH(AW),
    .WEIGHT_CELL_WIDTH(WW), .FRACTION_WIDTH(FW), .LEARNING_SHIFT(LS)
  ) dut (
    .clk(clk), .rst(rst), .delta(delta), .delta_valid(delta_valid), .delta_ready(delta_ready),
    .a(a), .a_valid(a_valid), .a_ready(a_ready), .weight_addr(weight_addr),
    .weight_read_data(weight_read_data), .weight_write_data(weight_write_data),
    .weight_write_enable(weight_write_enable), .done(done), .error(error)
  );

  typedef struct {
    int               row;
    logic [IN*WW-1:0] data;
    bit               err;
    longint           when;
  } exp_t;

  exp_t   exp_q[$];
  logic signed [WW-1:0] mem [N][IN];
  int     load_vals [N][IN];
  int     ref_mem [N][IN];
  int     cur_d [N];
  int     cur_a [IN];
  logic   load_en;
  longint cyc = 0;
  bit     active = 0;
  bit     reset_check = 0;
  bit     exp_err_final;
  longint t0 = 0;
  longint exp_done;
  int     accepts = 0;
  int     runs_done = 0;
  int     runs_target = 0;
  int     n_cmp = 0;
  int     n_fail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter used for timing expectations.
  always @(posedge clk) cyc <= cyc + 1;

  // Weight memory with one cycle read latency plus a bench preload port.
  always @(posedge clk) begin
    if (load_en) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < IN; j++) mem[i][j] <= WW'(load_vals[i][j]);
    end else if (weight_write_enable && weight_addr < N) begin
      for (int j = 0; j < IN; j++) mem[weight_addr][j] <= weight_write_data[j*WW +: WW];
    end
    if (weight_addr < N) begin
      for (int j = 0; j < IN; j++) weight_read_data[j*WW +: WW] <= mem[weight_addr][j];
    end else begin
      weight_read_data <= '0;
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Monitor: reset state, handshake, write scoreboard, done pulse.
  always @(negedge clk) begin
    bit     exp_ready;
    exp_t   e;
    bit     err_acc;
    longint p;
    longint s;
    longint sum;
    if (reset_check) begin
      checkOutput("reset_write_enable", weight_write_enable, 0);
      checkOutput("reset_done", done, 0);
      checkOutput("reset_error", error, 0);
      checkOutput("reset_write_data", weight_write_data, 0);
      checkOutput("reset_addr", weight_addr, 0);
      reset_check = 0;
    end
    exp_ready = rst && (!active || cyc >= t0 + 3*N + 2) && delta_valid && a_valid;
    checkOutput("delta_ready", delta_ready, exp_ready);
    checkOutput("a_ready", a_ready, exp_ready);
    if (weight_write_enable) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_write", weight_write_enable, 0);
      end else begin
        e = exp_q.pop_front();
        checkOutput($sformatf("write_cycle_row%0d", e.row), cyc, e.when);
        checkOutput($sformatf("write_addr_row%0d", e.row), weight_addr, e.row);
        checkOutput($sformatf("write_data_row%0d", e.row), weight_write_data, e.data);
        checkOutput($sformatf("error_at_row%0d", e.row), error, e.err);
        for (int j = 0; j < IN; j++) ref_mem[e.row][j] = int'($signed(e.data[j*WW +: WW]));
      end
    end
    if (done) begin
      if (!active) begin
        checkOutput("spurious_done", done, 0);
      end else begin
        checkOutput("done_cycle", cyc, exp_done);
        checkOutput("error_final", error, exp_err_final);
        checkOutput("writes_pending_at_done", exp_q.size(), 0);
      end
      runs_done++;
    end
    if (exp_ready) begin
      t0      = cyc;
      active  = 1;
      accepts++;
      err_acc = 0;
      for (int r = 0; r < N; r++) begin
        e.row  = r;
        e.data = '0;
        for (int j = 0; j < IN; j++) begin
          p   = longint'(cur_d[r]) * longint'(cur_a[j]);
          s   = p >>> SHIFT;
          sum = longint'(ref_mem[r][j]) + s;
          if (sum > WMAX) begin sum = WMAX; err_acc = 1; end
          if (sum < WMIN) begin sum = WMIN; err_acc = 1; end
          e.data[j*WW +: WW] = WW'(sum);
        end
        e.err  = err_acc;
        e.when = t0 + 3 + 3*r;
        exp_q.push_back(e);
      end
      exp_done      = t0 + 3*N + 1;
      exp_err_final = err_acc;
    end
    if (!rst) begin
      exp_q.delete();
      active      = 0;
      reset_check = 1;
    end
  end

  task automatic load_all(input int v);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < IN; j++) begin
        load_vals[i][j] = v;
        ref_mem[i][j]   = v;
      end
    load_en = 1'b1;
    @(posedge clk); #1;
    load_en = 1'b0;
  endtask

  task automatic load_random();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < IN; j++) begin
        load_vals[i][j] = int'($urandom_range(65535)) - 32768;
        ref_mem[i][j]   = load_vals[i][j];
      end
    load_en = 1'b1;
    @(posedge clk); #1;
    load_en = 1'b0;
  endtask

  task automatic set_operands(input int dv, input int av);
    for (int i = 0; i < N; i++) cur_d[i] = dv;
    for (int j = 0; j < IN; j++) cur_a[j] = av;
  endtask

  task automatic drive_buses();
    for (int i = 0; i < N; i++) delta[i*DW +: DW] = cur_d[i][DW-1:0];
    for (int j = 0; j < IN; j++) a[j*AW +: AW] = cur_a[j][AW-1:0];
  endtask

  task automatic applyStimulus(input bit hold);
    int start;
    int need;
    start = accepts;
    need  = hold ? 2 : 1;
    drive_buses();
    delta_valid = 1'b1;
    a_valid     = 1'b1;
    for (int k = 0; k < 200; k++) begin
      if (accepts - start >= need) break;
      @(posedge clk); #1;
    end
    if (accepts - start < need) checkOutput("accept_timeout", accepts - start, need);
    delta_valid = 1'b0;
    a_valid     = 1'b0;
    runs_target += need;
  endtask

  task automatic wait_runs();
    for (int k = 0; k < 100; k++) begin
      if (runs_done >= runs_target) break;
      @(posedge clk); #1;
    end
    if (runs_done < runs_target) begin
      checkOutput("run_timeout", runs_done, runs_target);
      runs_done = runs_target;
    end
    @(posedge clk); #1;
  endtask

  task automatic checkMemory(input string tag);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < IN; j++)
        checkOutput($sformatf("%s_mem[%0d][%0d]", tag, i, j), mem[i][j], ref_mem[i][j]);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst         = 1'b0;
    delta_valid = 1'b0;
    a_valid     = 1'b0;
    delta       = '0;
    a           = '0;
    load_en     = 1'b0;
    set_operands(0, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    $display("[TB] basic update");
    load_all(100);
    set_operands(16, 1);
    applyStimulus(0);
    wait_runs();
    checkMemory("basic");

    $display("[TB] floor rounding");
    load_all(100);
    set_operands(0, 0);
    cur_d[2] = -1;
    cur_a[0] = 1;
    for (int j = 1; j < IN; j++) cur_a[j] = int'($urandom_range(511));
    applyStimulus(0);
    wait_runs();
    checkMemory("floor");
    checkOutput("floor_row2_col0", mem[2][0], 99);

    $display("[TB] positive saturation");
    load_all(32767);
    set_operands(511, 511);
    applyStimulus(0);
    wait_runs();
    checkMemory("satpos");

    $display("[TB] negative saturation");
    load_all(-32768);
    set_operands(-512, 511);
    applyStimulus(0);
    wait_runs();
    checkMemory("satneg");

    $display("[TB] clean update after saturation");
    load_all(100);
    set_operands(16, 1);
    applyStimulus(0);
    wait_runs();
    checkMemory("clean");

    $display("[TB] lone valid handshake");
    load_all(100);
    set_operands(16, 1);
    drive_buses();
    delta_valid = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    applyStimulus(0);
    wait_runs();
    checkMemory("handshake");

    $display("[TB] reset during row 2");
    load_all(100);
    set_operands(16, 1);
    applyStimulus(0);
    for (int k = 0; k < 50; k++) begin
      if (cyc >= t0 + 8) break;
      @(posedge clk); #1;
    end
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    runs_target--;
    repeat (3) begin @(posedge clk); #1; end
    checkMemory("aborted");
    applyStimulus(0);
    wait_runs();
    checkMemory("after_reset");

    $display("[TB] back-to-back");
    load_all(100);
    set_operands(16, 1);
    applyStimulus(1);
    wait_runs();
    checkMemory("b2b");
    checkOutput("b2b_row0_col0", mem[0][0], 102);

    $display("[TB] random updates");
    for (int t = 0; t < 4; t++) begin
      load_random();
      for (int i = 0; i < N; i++) cur_d[i] = int'($urandom_range(1023)) - 512;
      for (int j = 0; j < IN; j++) cur_a[j] = int'($urandom_range(511));
      applyStimulus(0);
      wait_runs();
      checkMemory($sformatf("rand%0d", t));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
